parser_lit_arbiter: RTL and testbench

PARSER_LIT_ARBITER -- requirements
Module: parser_lit_arbiter

---
 rtl/parser_lit_arbiter_pkg.sv | 25 ++
 rtl/parser_lit_arbiter_if.sv | 23 ++
 rtl/parser_lit_arbiter_skid_buf.sv | 84 ++++++++
 rtl/parser_lit_arbiter.sv | 118 +++++++++++
 tb/tb_parser_lit_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parser_lit_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// parser_lit_pkg
//   Shared constants and types for the literal-parser output arbiter.
//   LIT_WIDTH   : literal token word width
//   NUM_LIT_REQ : number of literal parser FIFOs sharing the output port
//   LIT_SRC_W   : source-tag width, ceil(log2(NUM_LIT_REQ))
//   lit_entry_t : one output-buffer entry, {src, data}
// ---------------------------------------------------------------------------
package parser_lit_pkg;

  localparam int LIT_WIDTH   = 85;
  localparam int NUM_LIT_REQ = 4;
  localparam int LIT_SRC_W   = 2;

  typedef struct packed {
    logic [LIT_SRC_W-1:0] src;
    logic [LIT_WIDTH-1:0] data;
  } lit_entry_t;

  // Wraps an index that has overshot by at most one lap of n slots.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/parser_lit_arbiter_if.sv
// ---------------------------------------------------------------------------
// parser_lit_arbiter_if
//   Literal output stream: valid/ready handshake carrying a word and the
//   index of the source FIFO it came from.
//   lit_valid : word available          (master -> slave)
//   lit_data  : literal word            (master -> slave)
//   lit_src   : supplying source index  (master -> slave)
//   lit_ready : downstream accepts word (slave -> master)
// ---------------------------------------------------------------------------
interface parser_lit_arbiter_if #(
  parameter int WIDTH = parser_lit_pkg::LIT_WIDTH,
  parameter int SRC_W = parser_lit_pkg::LIT_SRC_W
);

  logic             lit_valid;
  logic [WIDTH-1:0] lit_data;
  logic [SRC_W-1:0] lit_src;
  logic             lit_ready;

  modport master (output lit_valid, output lit_data, output lit_src, input lit_ready);
  modport slave  (input lit_valid, input lit_data, input lit_src, output lit_ready);

endinterface

// File: rtl/parser_lit_arbiter_skid_buf.sv
// ---------------------------------------------------------------------------
// lit_skid_buf
//   Two-entry FIFO of {src, data} words feeding the literal output port.
//   The head entry drives the output directly, so the output never has a
//   combinational path from the write side.
//   clk, rst_n           : clock, async active-low reset
//   push, push_src/data  : write one entry at the tail
//   pop                  : remove the head entry (ignored when empty)
//   occ                  : occupancy 0..2
//   head_src, head_data  : head entry contents
// The caller guarantees no push arrives while full without a pop.
// ---------------------------------------------------------------------------
module lit_skid_buf #(
  parameter int WIDTH = 85,
  parameter int SRC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [SRC_W-1:0] push_src,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [SRC_W-1:0] head_src,
  output logic [WIDTH-1:0] head_data
);

  localparam int ENTRY_W = SRC_W + WIDTH;

  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] tail_q;
  logic [1:0]         occ_q;
  logic [ENTRY_W-1:0] push_ent;
  logic               do_pop;

  assign push_ent = {push_src, push_data};
  assign do_pop   = pop && (occ_q != 2'd0);

  // NOTE: both entries are reset, not just occupancy -- the head register is
  // the visible output and must read as zero out of reset.
  // NOTE: state is updated with non-blocking assignments so every register
  // in this block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_q <= push_ent;
            occ_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && do_pop) begin
            head_q <= push_ent;          // replace head, occupancy unchanged
          end else if (push) begin
            tail_q <= push_ent;
            occ_q  <= 2'd2;
          end else if (do_pop) begin
            occ_q  <= 2'd0;
          end
        end
        default: begin
          if (do_pop) begin
            head_q <= tail_q;            // tail advances to head
            if (push) begin
              tail_q <= push_ent;
            end else begin
              occ_q  <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign occ       = occ_q;
  assign head_src  = head_q[ENTRY_W-1:WIDTH];
  assign head_data = head_q[WIDTH-1:0];

endmodule

// File: rtl/parser_lit_arbiter.sv
// ---------------------------------------------------------------------------
// parser_lit_arbiter
//   Round-robin arbiter draining NUM_REQ literal parser FIFOs (fixed 1-cycle
//   read latency) into one valid/ready literal output port. A credit check
//   keeps at most two words owned by the arbiter (in flight + buffered), so
//   the 2-entry output buffer never overflows and a single busy source still
//   streams one word per cycle.
//   clk, rst_n  : clock, async active-low reset
//   req_en      : per-source arbitration enable
//   fifo_empty  : per-source empty flag
//   fifo_dout   : per-source read data, slice i = [i*WIDTH +: WIDTH]
//   fifo_rd_en  : per-source read strobe, one-hot or zero
//   busy        : read in flight or output buffer non-empty
//   lit         : literal output stream (master side)
// ---------------------------------------------------------------------------
module parser_lit_arbiter
  import parser_lit_pkg::*;
#(
  parameter int NUM_REQ = NUM_LIT_REQ,
  parameter int WIDTH   = LIT_WIDTH,
  parameter int SRC_W   = LIT_SRC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_en,
  input  logic [NUM_REQ-1:0]       fifo_empty,
  input  logic [NUM_REQ*WIDTH-1:0] fifo_dout,
  output logic [NUM_REQ-1:0]       fifo_rd_en,
  output logic                     busy,
  parser_lit_arbiter_if.master     lit
);

  logic [NUM_REQ-1:0] eligible;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_next;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               credit_ok;
  logic               issue;
  logic               pop;
  logic               inflight;
  logic [SRC_W-1:0]   inflight_src;
  logic [WIDTH-1:0]   cap_data;
  logic [1:0]         occ;
  int                 cand;

  assign eligible = req_en & ~fifo_empty;
  assign pop      = lit.lit_valid & lit.lit_ready;

  // occ + inflight - pop < 2, with pop moved to the right-hand side so the
  // unsigned arithmetic never goes negative.
  assign credit_ok = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

  // NOTE: every output of this block is given a default before the search
  // loop, so no path through it can leave a value held (no latch).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = rr_wrap(int'(rr_ptr) + off, NUM_REQ);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(cand);
      end
    end
  end

  // Gating with rst_n drops the strobe the instant reset asserts rather than
  // waiting for the registered state to clear.
  assign issue = grant_vld & credit_ok & rst_n;

  always_comb begin
    fifo_rd_en = '0;
    if (issue) begin
      fifo_rd_en[grant_idx] = 1'b1;
    end
  end

  assign rr_next = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_src <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rr_ptr       <= rr_next;
        inflight_src <= grant_idx;
      end
    end
  end

  // Source data is valid the cycle after the strobe; select it by the
  // remembered grant, independent of req_en changes since then.
  assign cap_data = fifo_dout[int'(inflight_src)*WIDTH +: WIDTH];

  lit_skid_buf #(
    .WIDTH (WIDTH),
    .SRC_W (SRC_W)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_src  (inflight_src),
    .push_data (cap_data),
    .pop       (pop),
    .occ       (occ),
    .head_src  (lit.lit_src),
    .head_data (lit.lit_data)
  );

  assign lit.lit_valid = (occ != 2'd0);
  assign busy          = inflight | (occ != 2'd0);

endmodule

// File: tb/tb_parser_lit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_parser_lit_arbiter
//   Directed and random-stimulus bench for parser_lit_arbiter. Source FIFOs
//   are modelled as per-source word stores with load/read counters and a
//   1-cycle read latency. Every word encodes its source and sequence number,
//   so expected output words are generated independently of the DUT.
// ---------------------------------------------------------------------------
module tb_parser_lit_arbiter;
  import parser_lit_pkg::*;

  localparam int N     = NUM_LIT_REQ;
  localparam int W     = LIT_WIDTH;
  localparam int DEPTH = 256;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_en = '0;
  logic [N-1:0]   fifo_empty;
  logic [N*W-1:0] fifo_dout;
  logic [N-1:0]   fifo_rd_en;
  logic           busy;

  parser_lit_arbiter_if #(.WIDTH(W), .SRC_W(LIT_SRC_W)) lit_bus ();

  logic [W-1:0] mem    [N][DEPTH];
  logic [W-1:0] dout_q [N] = '{default: '0};
  int           ld_cnt [N] = '{default: 0};
  int           rd_cnt [N] = '{default: 0};
  logic         srst = 1'b0;

  int errors = 0;
  int checks = 0;

  int viol = 0;
  int order_err = 0;
  int onehot_err = 0;
  bit mon_on = 1'b0;
  int exp_seq [N] = '{default: 0};

  always #5 clk = ~clk;

  parser_lit_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_en     (req_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .busy       (busy),
    .lit        (lit_bus)
  );

  // Source FIFO model ------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]        = (ld_cnt[i] == rd_cnt[i]);
      fifo_dout[i*W +: W]  = dout_q[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (srst) begin
        rd_cnt[i] <= 0;
      end else if (fifo_rd_en[i]) begin
        if (ld_cnt[i] == rd_cnt[i]) viol++;
        dout_q[i] <= mem[i][rd_cnt[i] % DEPTH];
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  end

  // Random-phase monitors ---------------------------------------------------
  always @(posedge clk) begin
    if (mon_on && lit_bus.lit_valid && lit_bus.lit_ready) begin
      if (lit_bus.lit_data !== word(int'(lit_bus.lit_src), exp_seq[lit_bus.lit_src])) order_err++;
      exp_seq[lit_bus.lit_src] = exp_seq[lit_bus.lit_src] + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_on && !$onehot0(fifo_rd_en)) onehot_err++;
  end

  // Helpers -----------------------------------------------------------------
  function automatic logic [W-1:0] word(input int s, input int n);
    logic [W-1:0] v;
    v           = '0;
    v[7:0]      = 8'(s);
    v[31:8]     = 24'(n);
    v[W-1:W-32] = 32'(n * 32'h9E37 + s * 32'h51);
    return v;
  endfunction

  task automatic load(input int s, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      mem[s][ld_cnt[s] % DEPTH] = word(s, ld_cnt[s]);
      ld_cnt[s] = ld_cnt[s] + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_en = '1;
    lit_bus.lit_ready = 1'b1;
    srst = 1'b1;
    for (int i = 0; i < N; i++) ld_cnt[i] = 0;
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Tests -------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1;
    lit_bus.lit_ready = 1'b1;
    #1 rst_n = 1'b0;
    req_en = '1;
    load(3, 1);                      // a non-empty source must not be read
    #1;
    checks++; if (fifo_rd_en !== 4'b0000) begin errors++; $display("FAIL reset_rd_en: got %b want 0000", fifo_rd_en); end
    checks++; if (lit_bus.lit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", lit_bus.lit_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (lit_bus.lit_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", lit_bus.lit_data); end
    checks++; if (lit_bus.lit_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", lit_bus.lit_src); end
    repeat (2) @(negedge clk);
    checks++; if (fifo_rd_en !== 4'b0000 || lit_bus.lit_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold: rd_en=%b valid=%b want 0000/0", fifo_rd_en, lit_bus.lit_valid);
    end
    do_reset();
  endtask

  task automatic test_single_source();
    logic [3:0] exp_rd;
    bit         exp_v;
    do_reset();
    @(negedge clk);
    load(1, 3);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_rd = (c < 3) ? 4'b0010 : 4'b0000;
      exp_v  = (c >= 2 && c <= 4);
      checks++; if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL single_rd_en c%0d: got %b want %b", c, fifo_rd_en, exp_rd); end
      checks++; if (lit_bus.lit_valid !== exp_v) begin errors++; $display("FAIL single_valid c%0d: got %b want %b", c, lit_bus.lit_valid, exp_v); end
      if (exp_v) begin
        checks++; if (lit_bus.lit_data !== word(1, c - 2)) begin errors++; $display("FAIL single_data c%0d: got %h want %h", c, lit_bus.lit_data, word(1, c - 2)); end
        checks++; if (lit_bus.lit_src !== 2'd1) begin errors++; $display("FAIL single_src c%0d: got %0d want 1", c, lit_bus.lit_src); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rd;
    int         k;
    do_reset();
    @(negedge clk);
    for (int s = 0; s < N; s++) load(s, 2);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_rd = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      checks++; if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL rr_rd_en c%0d: got %b want %b", c, fifo_rd_en, exp_rd); end
      if (c >= 2 && c < 10) begin
        k = c - 2;
        checks++; if (lit_bus.lit_valid !== 1'b1 || lit_bus.lit_src !== 2'(k % 4)) begin
          errors++; $display("FAIL rr_src c%0d: valid=%b src=%0d want 1/%0d", c, lit_bus.lit_valid, lit_bus.lit_src, k % 4);
        end
        checks++; if (lit_bus.lit_data !== word(k % 4, k / 4)) begin errors++; $display("FAIL rr_data c%0d: got %h want %h", c, lit_bus.lit_data, word(k % 4, k / 4)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rd;
    int         nrd;
    int         got;
    do_reset();
    @(negedge clk);
    lit_bus.lit_ready = 1'b0;
    load(0, 5);
    nrd = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      nrd += $countones(fifo_rd_en);
      exp_rd = (c < 2) ? 4'b0001 : 4'b0000;
      checks++; if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL bp_rd_en c%0d: got %b want %b", c, fifo_rd_en, exp_rd); end
      if (c >= 2) begin
        checks++; if (lit_bus.lit_valid !== 1'b1 || lit_bus.lit_data !== word(0, 0) || lit_bus.lit_src !== 2'd0) begin
          errors++; $display("FAIL bp_hold c%0d: valid=%b data=%h src=%0d want 1/%h/0", c, lit_bus.lit_valid, lit_bus.lit_data, lit_bus.lit_src, word(0, 0));
        end
      end
    end
    checks++; if (nrd !== 2) begin errors++; $display("FAIL bp_reads: got %0d want 2", nrd); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy); end
    @(negedge clk);
    lit_bus.lit_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (lit_bus.lit_valid && lit_bus.lit_ready) begin
        checks++; if (lit_bus.lit_data !== word(0, got) || lit_bus.lit_src !== 2'd0) begin
          errors++; $display("FAIL bp_drain w%0d: got %h/%0d want %h/0", got, lit_bus.lit_data, lit_bus.lit_src, word(0, got));
        end
        got++;
      end
    end
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_req_drop();
    int extra;
    do_reset();
    @(negedge clk);
    load(2, 3);
    #1;
    checks++; if (fifo_rd_en !== 4'b0100) begin errors++; $display("FAIL drop_rd0: got %b want 0100", fifo_rd_en); end
    @(negedge clk);
    req_en[2] = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 4'b0000) begin errors++; $display("FAIL drop_rd1: got %b want 0000", fifo_rd_en); end
    @(negedge clk);
    #1;
    checks++; if (lit_bus.lit_valid !== 1'b1 || lit_bus.lit_src !== 2'd2 || lit_bus.lit_data !== word(2, 0)) begin
      errors++; $display("FAIL drop_word: valid=%b src=%0d data=%h want 1/2/%h", lit_bus.lit_valid, lit_bus.lit_src, lit_bus.lit_data, word(2, 0));
    end
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      extra += $countones(fifo_rd_en) + int'(lit_bus.lit_valid);
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL drop_no_more: got %0d events want 0", extra); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    lit_bus.lit_ready = 1'b0;
    load(1, 5);
    repeat (2) @(negedge clk);
    #1;
    // One word buffered and one in flight at this point.
    checks++; if (lit_bus.lit_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: valid=%b busy=%b want 1/1", lit_bus.lit_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (lit_bus.lit_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", lit_bus.lit_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (fifo_rd_en !== 4'b0000) begin errors++; $display("FAIL mid_rd_en: got %b want 0000", fifo_rd_en); end
    checks++; if (lit_bus.lit_data !== '0 || lit_bus.lit_src !== 2'd0) begin
      errors++; $display("FAIL mid_head: data=%h src=%0d want 0/0", lit_bus.lit_data, lit_bus.lit_src);
    end
    srst = 1'b1;
    for (int i = 0; i < N; i++) ld_cnt[i] = 0;
    @(negedge clk);
    srst = 1'b0;
    lit_bus.lit_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < N; s++) load(s, 1);
    #1;
    checks++; if (fifo_rd_en !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", fifo_rd_en); end
    @(negedge clk);
    #1;
    checks++; if (fifo_rd_en !== 4'b0010) begin errors++; $display("FAIL mid_second_grant: got %b want 0010", fifo_rd_en); end
  endtask

  task automatic test_random();
    bit done;
    do_reset();
    viol = 0; order_err = 0; onehot_err = 0;
    for (int i = 0; i < N; i++) exp_seq[i] = 0;
    mon_on = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      lit_bus.lit_ready = ($urandom_range(0, 3) != 0);
      req_en = 4'($urandom);
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 2) == 0 && (ld_cnt[s] - rd_cnt[s]) < 200) load(s, 1);
      end
    end
    @(negedge clk);
    req_en = '1;
    lit_bus.lit_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge clk);
      done = (&fifo_empty) && !busy;
    end
    mon_on = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rand_drain_timeout: busy=%b empty=%b", busy, fifo_empty); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL rand_empty_read: got %0d want 0", viol); end
    checks++; if (order_err !== 0) begin errors++; $display("FAIL rand_order: got %0d bad words want 0", order_err); end
    checks++; if (onehot_err !== 0) begin errors++; $display("FAIL rand_onehot: got %0d cycles want 0", onehot_err); end
    for (int s = 0; s < N; s++) begin
      checks++; if (exp_seq[s] !== ld_cnt[s]) begin errors++; $display("FAIL rand_count src%0d: got %0d want %0d", s, exp_seq[s], ld_cnt[s]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
